// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port word memory between the instruction-fetch port and
// the load/store data port. One transaction is outstanding at a time. The data
// port wins ties unless the fetch port has lost STARVE_MAX grant slots in a
// row, in which case the fetch is forced through.
//
// Optional feature: define ARB_PERF_CNT_EN to add the saturating wait-cycle
// counters perf_if_wait / perf_d_wait (cycles with req high and gnt low).
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]   perf_if_wait,
    output logic [31:0]   perf_d_wait,
`endif
    input  logic [DW-1:0] mem_rdata
);

    // Counter widths; the latency counter holds MEM_LAT-1 down to 0.
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {
        IDLE,
        BUSY
    } arbState_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

    arbState_e     state, nextState;
    logic [CW-1:0] cnt, nextCnt;
    logic [SW-1:0] starve, nextStarve;
    owner_e        owner, nextOwner;
    logic          ownerStore, nextOwnerStore;

    logic          complete;
    logic          canGrant;
    logic          ifWins;
    logic          anyGnt;

    // ------------------------------------------------------------------
    // Arbitration (combinational grant)
    // ------------------------------------------------------------------

    // The completion cycle is the one where the read data for the current
    // owner is on mem_rdata; a new grant may overlap it.
    assign complete = (state == BUSY) && (cnt == '0);

    // Gating with rst keeps every output at 0 while reset is asserted, even
    // if requesters hold req high through reset.
    assign canGrant = rst && ((state == IDLE) || complete);

    // Fetch wins when it is alone or when it has been starved long enough.
    assign ifWins = if_req && (!d_req || (starve == STARVE_TOP));

    assign if_gnt = canGrant && ifWins;
    assign d_gnt  = canGrant && d_req && !ifWins;
    assign anyGnt = if_gnt || d_gnt;

    // ------------------------------------------------------------------
    // Memory command: driven only in a grant cycle, zero otherwise
    // ------------------------------------------------------------------
    assign mem_en    = anyGnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
    assign mem_wdata = (d_gnt && d_we) ? d_wdata : '0;

    // ------------------------------------------------------------------
    // Responses: one-cycle rvalid to the owner; stores return zero data
    // ------------------------------------------------------------------
    assign if_rvalid = complete && (owner == OWN_IF);
    assign d_rvalid  = complete && (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !ownerStore) ? mem_rdata : '0;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------

    // Next-state logic: grant reloads the latency counter, completion without
    // a new grant returns to IDLE, otherwise the counter runs down.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        nextState      = state;
        nextCnt        = cnt;
        nextOwner      = owner;
        nextOwnerStore = ownerStore;

        if (anyGnt) begin
            nextState      = BUSY;
            nextCnt        = CNT_LOAD;
            nextOwner      = if_gnt ? OWN_IF : OWN_D;
            nextOwnerStore = d_gnt && d_we;
        end else if (complete) begin
            nextState      = IDLE;
            nextCnt        = '0;
            nextOwner      = OWN_NONE;
            nextOwnerStore = 1'b0;
        end else if (state == BUSY) begin
            nextCnt = cnt - CW'(1);
        end
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its peers.
            state      <= IDLE;
            cnt        <= '0;
            owner      <= OWN_NONE;
            ownerStore <= 1'b0;
        end else begin
            state      <= nextState;
            cnt        <= nextCnt;
            owner      <= nextOwner;
            ownerStore <= nextOwnerStore;
        end
    end

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------

    // Count grant slots the fetch port loses while requesting; clear when it
    // wins or stops asking; hold at STARVE_MAX.
    always_comb begin
        nextStarve = starve;
        if (!if_req || if_gnt) begin
            nextStarve = '0;
        end else if (d_gnt && (starve != STARVE_TOP)) begin
            nextStarve = starve + SW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else begin
            starve <= nextStarve;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Wait-cycle performance counters (saturating)
    // ------------------------------------------------------------------

    // Count cycles each port spends stalled with req high and no grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_req && !if_gnt && (perf_if_wait != 32'hFFFF_FFFF)) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (d_req && !d_gnt && (perf_d_wait != 32'hFFFF_FFFF)) begin
                perf_d_wait <= perf_d_wait + 32'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------

    // Both ports can never be granted in the same cycle.
    gntExclusive : assert property (@(posedge clk) disable iff (!rst) !(if_gnt && d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4. A small
// memory model with a two-stage read pipeline answers commands; unread cycles
// put 32'hDEAD_BEEF on mem_rdata so zero-gating of rdata is visible.
// Inputs are driven 1 time unit after the rising edge and outputs sampled on
// the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_if_wait;
    logic [31:0]   perf_d_wait;
`endif

    int vecCount  = 0;
    int missCount = 0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef ARB_PERF_CNT_EN
        .perf_if_wait (perf_if_wait),
        .perf_d_wait  (perf_d_wait),
`endif
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed contents for a few addresses, writable overlay.
    bit [DW-1:0] wrData [256];
    bit          wrDone [256];
    logic [DW-1:0] rdStage1 = 32'hDEAD_BEEF;
    logic [DW-1:0] rdStage2 = 32'hDEAD_BEEF;

    function automatic logic [DW-1:0] baseWord(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h0020_1820;
            8'd4:    return 32'h1111_0004;
            8'd18:   return 32'hA5A5_0012;
            default: return 32'h5A00_0000 | {24'd0, a};
        endcase
    endfunction

    function automatic logic [DW-1:0] readWord(input logic [7:0] a);
        return wrDone[a] ? wrData[a] : baseWord(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wrData[mem_addr[7:0]] <= mem_wdata;
            wrDone[mem_addr[7:0]] <= 1'b1;
        end
        rdStage1 <= (mem_en && !mem_we) ? readWord(mem_addr[7:0]) : 32'hDEAD_BEEF;
        rdStage2 <= rdStage1;
    end
    assign mem_rdata = rdStage2;

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    // Reset: all outputs 0 even with both requests asserted during reset.
    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'd4;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'd9; d_wdata = 32'hFFFF_0000;
        @(negedge clk);
        vecCount++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
            missCount++; $display("FAIL reset_gnt: got if/d/en/we=%b want 0000", {if_gnt, d_gnt, mem_en, mem_we});
        end
        vecCount++; if ({mem_addr, mem_wdata} !== '0) begin
            missCount++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        vecCount++; if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== '0) begin
            missCount++; $display("FAIL reset_resp: got ifv=%b dv=%b ifd=%h dd=%h want 0", if_rvalid, d_rvalid, if_rdata, d_rdata);
        end
`ifdef ARB_PERF_CNT_EN
        vecCount++; if ({perf_if_wait, perf_d_wait} !== 64'd0) begin
            missCount++; $display("FAIL reset_perf: got if=%0d d=%0d want 0 0", perf_if_wait, perf_d_wait);
        end
`endif
        nextCycle();
        idleInputs();
        nextCycle();
        rst = 1'b1;
        nextCycle();
    endtask

    // Single fetch from address 0, latency 2.
    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 16'd0;
        @(negedge clk);
        vecCount++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin
            missCount++; $display("FAIL fetch_grant: got if/d/en/we=%b want 1010", {if_gnt, d_gnt, mem_en, mem_we});
        end
        vecCount++; if (mem_addr !== 16'd0) begin
            missCount++; $display("FAIL fetch_addr: got %h want 0000", mem_addr);
        end
        nextCycle();
        if_req = 1'b0;
        @(negedge clk);
        vecCount++; if ({if_rvalid, mem_en, mem_addr} !== '0) begin
            missCount++; $display("FAIL fetch_n1_quiet: got rvalid=%b en=%b addr=%h want 0", if_rvalid, mem_en, mem_addr);
        end
        nextCycle();
        @(negedge clk);
        vecCount++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0020_1820) begin
            missCount++; $display("FAIL fetch_data: got rvalid=%b rdata=%h want 1 00201820", if_rvalid, if_rdata);
        end
        vecCount++; if (d_rvalid !== 1'b0) begin
            missCount++; $display("FAIL fetch_no_drvalid: got %b want 0", d_rvalid);
        end
        nextCycle();
        @(negedge clk);
        vecCount++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin
            missCount++; $display("FAIL fetch_pulse_end: got rvalid=%b rdata=%h want 0 0", if_rvalid, if_rdata);
        end
        nextCycle();
    endtask

    // Tie: data load wins, fetch granted in the data completion cycle.
    task automatic test_tie();
        if_req = 1'b1; if_addr = 16'd4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd18;
        @(negedge clk);
        vecCount++; if ({d_gnt, if_gnt} !== 2'b10 || mem_addr !== 16'd18) begin
            missCount++; $display("FAIL tie_first: got d/if=%b addr=%h want 10 0012", {d_gnt, if_gnt}, mem_addr);
        end
        nextCycle();
        d_req = 1'b0;
        @(negedge clk);
        vecCount++; if ({d_gnt, if_gnt} !== 2'b00) begin
            missCount++; $display("FAIL tie_busy: got d/if=%b want 00", {d_gnt, if_gnt});
        end
        nextCycle();
        @(negedge clk);
        vecCount++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0012) begin
            missCount++; $display("FAIL tie_load_data: got rvalid=%b rdata=%h want 1 a5a50012", d_rvalid, d_rdata);
        end
        vecCount++; if (if_gnt !== 1'b1 || mem_addr !== 16'd4) begin
            missCount++; $display("FAIL tie_if_gnt: got gnt=%b addr=%h want 1 0004", if_gnt, mem_addr);
        end
        nextCycle();
        if_req = 1'b0;
        nextCycle();
        @(negedge clk);
        vecCount++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1111_0004) begin
            missCount++; $display("FAIL tie_fetch_data: got rvalid=%b rdata=%h want 1 11110004", if_rvalid, if_rdata);
        end
        nextCycle();
    endtask

    // Starvation: continuous data loads; fetch forced on the 5th slot, then
    // the counter is cleared so the data port wins the 6th slot again.
    task automatic test_starvation();
        logic [1:0] want;
        if_req = 1'b1; if_addr = 16'd0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd18;
        for (int s = 0; s < 6; s++) begin
            want = (s == 4) ? 2'b10 : 2'b01;
            @(negedge clk);
            vecCount++; if ({if_gnt, d_gnt} !== want) begin
                missCount++; $display("FAIL starve_slot%0d: got if/d=%b want %b", s, {if_gnt, d_gnt}, want);
            end
            nextCycle();
            @(negedge clk);
            vecCount++; if ({if_gnt, d_gnt} !== 2'b00) begin
                missCount++; $display("FAIL starve_gap%0d: got if/d=%b want 00", s, {if_gnt, d_gnt});
            end
            nextCycle();
        end
        idleInputs();
        nextCycle();
        nextCycle();
    endtask

    // Store then load of the same word; store ack carries zero data.
    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'd20; d_wdata = 32'h0000_0003;
        @(negedge clk);
        vecCount++; if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 16'd20 || mem_wdata !== 32'd3) begin
            missCount++; $display("FAIL store_cmd: got gnt/en/we=%b addr=%h wdata=%h want 111 0014 00000003",
                                  {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        nextCycle();
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        nextCycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd20;
        @(negedge clk);
        vecCount++; if (d_rvalid !== 1'b1 || d_rdata !== 32'd0) begin
            missCount++; $display("FAIL store_ack: got rvalid=%b rdata=%h want 1 00000000", d_rvalid, d_rdata);
        end
        vecCount++; if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin
            missCount++; $display("FAIL load_b2b_gnt: got gnt=%b we=%b wdata=%h want 1 0 0", d_gnt, mem_we, mem_wdata);
        end
        nextCycle();
        d_req = 1'b0;
        nextCycle();
        @(negedge clk);
        vecCount++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_0003) begin
            missCount++; $display("FAIL load_after_store: got rvalid=%b rdata=%h want 1 00000003", d_rvalid, d_rdata);
        end
        nextCycle();
    endtask

    // Reset one cycle after a load grant: no response, outputs cleared at
    // once, first request after release is granted immediately.
    task automatic test_reset_midop();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd18;
        @(negedge clk);
        vecCount++; if (d_gnt !== 1'b1) begin
            missCount++; $display("FAIL midop_gnt: got %b want 1", d_gnt);
        end
        nextCycle();
        d_req = 1'b0;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 16'd0;
        @(negedge clk);
        vecCount++; if ({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid} !== 5'b00000 || mem_addr !== '0) begin
            missCount++; $display("FAIL midop_outputs: got gnt/en/rv=%b addr=%h want 00000 0000",
                                  {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}, mem_addr);
        end
        nextCycle();
        rst = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        vecCount++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin
            missCount++; $display("FAIL midop_dropped: got rvalid=%b rdata=%h want 0 0", d_rvalid, d_rdata);
        end
        nextCycle();
        if_req = 1'b1; if_addr = 16'd0;
        @(negedge clk);
        vecCount++; if (if_gnt !== 1'b1 || d_rvalid !== 1'b0) begin
            missCount++; $display("FAIL midop_regrant: got if_gnt=%b d_rvalid=%b want 1 0", if_gnt, d_rvalid);
        end
        nextCycle();
        if_req = 1'b0;
        nextCycle();
        @(negedge clk);
        vecCount++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0020_1820) begin
            missCount++; $display("FAIL midop_fetch_data: got rvalid=%b rdata=%h want 1 00201820", if_rvalid, if_rdata);
        end
        nextCycle();
    endtask

`ifdef ARB_PERF_CNT_EN
    // Fetch granted alone, load raised the next cycle: it stalls one cycle
    // (the busy cycle) and is granted in the fetch completion cycle.
    task automatic test_perf();
        rst = 1'b0;
        nextCycle();
        rst = 1'b1;
        nextCycle();
        if_req = 1'b1; if_addr = 16'd0;
        nextCycle();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd18;
        nextCycle();
        @(negedge clk);
        vecCount++; if (d_gnt !== 1'b1) begin
            missCount++; $display("FAIL perf_dgnt: got %b want 1", d_gnt);
        end
        nextCycle();
        d_req = 1'b0;
        @(negedge clk);
        vecCount++; if (perf_d_wait !== 32'd1 || perf_if_wait !== 32'd0) begin
            missCount++; $display("FAIL perf_counts: got d=%0d if=%0d want 1 0", perf_d_wait, perf_if_wait);
        end
        nextCycle();
        nextCycle();
    endtask
`endif

    initial begin
        rst = 1'b0;
        idleInputs();
        #1;
        test_reset();
        test_single_fetch();
        test_tie();
        test_starvation();
        test_store_load();
        test_reset_midop();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
